// File: rtl/font_rom_arbiter_if.sv
// font_rom_arbiter_if
//   Bundles the requester-side and ROM-side signals of the font ROM arbiter.
//   Parameters: N requesters, AW address bits, DW data bits.
//   Signals:
//     req[N], lock[N], addr_in[N*AW]  requests from text generators
//     gnt[N], rom_addr[AW]            registered grant and ROM address
//     rom_data[DW]                    registered font ROM output
//     rd_valid[N], rd_data[DW]        tagged read return
//     busy                            arbiter is inside a locked burst
//   Modports: master = requesters + ROM model, slave = arbiter.
interface font_rom_arbiter_if #(
  parameter int N  = 4,
  parameter int AW = 11,
  parameter int DW = 8
);
  logic [N-1:0]    req;
  logic [N-1:0]    lock;
  logic [N*AW-1:0] addr_in;
  logic [N-1:0]    gnt;
  logic [AW-1:0]   rom_addr;
  logic [DW-1:0]   rom_data;
  logic [N-1:0]    rd_valid;
  logic [DW-1:0]   rd_data;
  logic            busy;

  modport master (
    output req, lock, addr_in, rom_data,
    input  gnt, rom_addr, rd_valid, rd_data, busy
  );

  modport slave (
    input  req, lock, addr_in, rom_data,
    output gnt, rom_addr, rd_valid, rd_data, busy
  );
endinterface

// File: rtl/font_rom_arbiter.sv
// font_rom_arbiter
//   Shares one registered single-port font ROM between N text generators.
//   Round-robin arbitration, one read per cycle, locked bursts of up to
//   MAX_BURST back-to-back grants to a single requester.
//   Ports:
//     clk    system clock
//     reset  asynchronous, active-high reset
//     bus    font_rom_arbiter_if.slave (req/lock/addr_in in, gnt/rom_addr
//            out, rom_data in, rd_valid/rd_data/busy out)
//   Optional build macro ARB_FIXED_PRIO_EN: fixed priority (lowest index
//   wins) instead of round-robin; the rotation pointer stays at 0.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | arbitrate every cycle among all requesters
//   BURST | owner keeps the ROM while req&lock held and bcnt < MAX_BURST
module font_rom_arbiter #(
  parameter int N         = 4,
  parameter int AW        = 11,
  parameter int DW        = 8,
  parameter int MAX_BURST = 16
) (
  input logic             clk,
  input logic             reset,
  font_rom_arbiter_if.slave bus
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t        state, state_n;
  logic [PW-1:0] ptr, ptr_n;
  logic [PW-1:0] owner, owner_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [N-1:0]  gnt_n;
  logic [AW-1:0] addr_n;
  logic          found;
  logic [PW-1:0] win;
  logic          hold;

  // First set req bit searching upward from ptr with wrap. In the fixed
  // priority build ptr never leaves 0, so this degenerates to lowest-index.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (int'(ptr) + k) % N;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  always_comb begin
    int oi;
    int wi;
    state_n = state;
    ptr_n   = ptr;
    owner_n = owner;
    bcnt_n  = bcnt;
    gnt_n   = '0;
    addr_n  = bus.rom_addr;
    oi      = int'(owner);
    wi      = int'(win);
    hold    = (state == BURST) && bus.req[oi] && bus.lock[oi] &&
              (bcnt < BW'(MAX_BURST));
    if (hold) begin
      gnt_n[oi] = 1'b1;
      addr_n    = bus.addr_in[oi*AW +: AW];
      bcnt_n    = bcnt + BW'(1);
    end else begin
      // Burst exit falls through to normal arbitration in the same cycle,
      // so there is no bubble; ptr already points past the old owner.
      state_n = IDLE;
      bcnt_n  = '0;
      if (found) begin
        gnt_n[wi] = 1'b1;
        addr_n    = bus.addr_in[wi*AW +: AW];
        owner_n   = win;
`ifdef ARB_FIXED_PRIO_EN
        ptr_n     = '0;
`else
        ptr_n     = (wi == N - 1) ? '0 : win + PW'(1);
`endif
        if (bus.lock[wi]) begin
          state_n = BURST;
          bcnt_n  = BW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      ptr          <= '0;
      owner        <= '0;
      bcnt         <= '0;
      bus.gnt      <= '0;
      bus.rom_addr <= '0;
      bus.rd_valid <= '0;
    end else begin
      state        <= state_n;
      ptr          <= ptr_n;
      owner        <= owner_n;
      bcnt         <= bcnt_n;
      bus.gnt      <= gnt_n;
      bus.rom_addr <= addr_n;
      // The ROM captures rom_addr on this same edge, so the returned word
      // lines up with gnt delayed by one cycle.
      bus.rd_valid <= bus.gnt;
    end
  end

  assign bus.rd_data = bus.rom_data;
  assign bus.busy    = (state == BURST);
endmodule

// File: tb/tb_font_rom_arbiter.sv
module tb_font_rom_arbiter;
  logic clk;
  logic reset;

  font_rom_arbiter_if #(.N(4), .AW(11), .DW(8)) bus ();

  font_rom_arbiter #(.N(4), .AW(11), .DW(8), .MAX_BURST(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered font ROM model owned by the bench.
  logic [7:0] rom [0:2047];
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  typedef struct {
    bit         rst;
    logic [3:0] req;
    logic [3:0] lock;
    logic [43:0] addr;
    logic [3:0] gnt;
    logic [3:0] rdv;
    logic [7:0] data;
    logic       busy;
  } vec_t;

  vec_t tbl[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [43:0] mk(logic [10:0] a0, logic [10:0] a1,
                                     logic [10:0] a2, logic [10:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic void add(bit rst, logic [3:0] req, logic [3:0] lock,
                              logic [43:0] addr, logic [3:0] gnt,
                              logic [3:0] rdv, logic [7:0] data, logic busy);
    vec_t v;
    v.rst = rst; v.req = req; v.lock = lock; v.addr = addr;
    v.gnt = gnt; v.rdv = rdv; v.data = data; v.busy = busy;
    tbl.push_back(v);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_table();
    for (int i = 0; i < tbl.size(); i++) begin
      logic [10:0] ea;
      if (tbl[i].rst) begin
        @(negedge clk);
        bus.req = '0; bus.lock = '0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
      @(negedge clk);
      bus.req     = tbl[i].req;
      bus.lock    = tbl[i].lock;
      bus.addr_in = tbl[i].addr;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d gnt", i), 32'(bus.gnt), 32'(tbl[i].gnt));
      chk($sformatf("row%0d rd_valid", i), 32'(bus.rd_valid), 32'(tbl[i].rdv));
      chk($sformatf("row%0d busy", i), 32'(bus.busy), 32'(tbl[i].busy));
      if (tbl[i].rdv != 4'b0)
        chk($sformatf("row%0d rd_data", i), 32'(bus.rd_data), 32'(tbl[i].data));
      if (tbl[i].gnt != 4'b0) begin
        ea = '0;
        for (int j = 0; j < 4; j++)
          if (tbl[i].gnt[j]) ea = tbl[i].addr[j*11 +: 11];
        chk($sformatf("row%0d rom_addr", i), 32'(bus.rom_addr), 32'(ea));
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) rom[a] = 8'(a) ^ 8'hA5;
    rom[11'h022] = 8'h18;
    rom[11'h000] = 8'hFF;
    rom[11'h020] = 8'h00;
    rom[11'h100] = 8'hF0;
    rom[11'h0A0] = 8'hFC;

    reset = 1'b1;
    bus.req = '0; bus.lock = '0; bus.addr_in = '0;
    repeat (2) @(negedge clk);
    chk("reset gnt", 32'(bus.gnt), 32'h0);
    chk("reset rd_valid", 32'(bus.rd_valid), 32'h0);
    chk("reset busy", 32'(bus.busy), 32'h0);
    chk("reset rom_addr", 32'(bus.rom_addr), 32'h0);
    reset = 1'b0;

`ifdef ARB_FIXED_PRIO_EN
    // Fixed priority: requester 1 always beats requester 3.
    add(0, 4'b1010, 4'b0, mk(0, 11'h022, 0, 11'h0A0), 4'b0010, 4'b0000, 8'h00, 0);
    for (int k = 0; k < 6; k++)
      add(0, 4'b1010, 4'b0, mk(0, 11'h022, 0, 11'h0A0), 4'b0010, 4'b0010, 8'h18, 0);
    add(0, 4'b0000, 4'b0, mk(0, 11'h022, 0, 11'h0A0), 4'b0000, 4'b0010, 8'h18, 0);
    run_table();
`else
    // Single request from requester 0.
    add(0, 4'b0001, 4'b0, mk(11'h022, 0, 0, 0), 4'b0001, 4'b0000, 8'h00, 0);
    add(0, 4'b0000, 4'b0, mk(11'h022, 0, 0, 0), 4'b0000, 4'b0001, 8'h18, 0);
    add(0, 4'b0000, 4'b0, mk(11'h022, 0, 0, 0), 4'b0000, 4'b0000, 8'h00, 0);
    // Full rotation after a fresh reset.
    add(1, 4'b1111, 4'b0, mk(11'h000, 11'h020, 11'h100, 11'h0A0), 4'b0001, 4'b0000, 8'h00, 0);
    add(0, 4'b1111, 4'b0, mk(11'h000, 11'h020, 11'h100, 11'h0A0), 4'b0010, 4'b0001, 8'hFF, 0);
    add(0, 4'b1111, 4'b0, mk(11'h000, 11'h020, 11'h100, 11'h0A0), 4'b0100, 4'b0010, 8'h00, 0);
    add(0, 4'b1111, 4'b0, mk(11'h000, 11'h020, 11'h100, 11'h0A0), 4'b1000, 4'b0100, 8'hF0, 0);
    add(0, 4'b1111, 4'b0, mk(11'h000, 11'h020, 11'h100, 11'h0A0), 4'b0001, 4'b1000, 8'hFC, 0);
    add(0, 4'b0000, 4'b0, mk(11'h000, 11'h020, 11'h100, 11'h0A0), 4'b0000, 4'b0001, 8'hFF, 0);
    add(0, 4'b0000, 4'b0, mk(11'h000, 11'h020, 11'h100, 11'h0A0), 4'b0000, 4'b0000, 8'h00, 0);
    // Locked 16-row burst by requester 2 with requester 0 waiting (ptr=1).
    for (int k = 0; k < 16; k++)
      add(0, 4'b0101, 4'b0100, mk(11'h000, 0, 11'(11'h100 + k), 0), 4'b0100,
          (k == 0) ? 4'b0000 : 4'b0100,
          (k == 0) ? 8'h00 : rom[11'(11'h100 + k - 1)], 1);
    add(0, 4'b0101, 4'b0100, mk(11'h000, 0, 11'h110, 0), 4'b0001, 4'b0100, rom[11'h10F], 0);
    add(0, 4'b0000, 4'b0000, mk(11'h000, 0, 11'h110, 0), 4'b0000, 4'b0001, 8'hFF, 0);
    add(0, 4'b0000, 4'b0000, mk(11'h000, 0, 11'h110, 0), 4'b0000, 4'b0000, 8'h00, 0);
    // Burst by requester 1, lock drops after 3 rows (ptr=1 here).
    add(0, 4'b1110, 4'b0010, mk(0, 11'h020, 11'h0A0, 11'h000), 4'b0010, 4'b0000, 8'h00, 1);
    add(0, 4'b1110, 4'b0010, mk(0, 11'h021, 11'h0A0, 11'h000), 4'b0010, 4'b0010, 8'h00, 1);
    add(0, 4'b1110, 4'b0010, mk(0, 11'h022, 11'h0A0, 11'h000), 4'b0010, 4'b0010, rom[11'h021], 1);
    add(0, 4'b1110, 4'b0000, mk(0, 11'h022, 11'h0A0, 11'h000), 4'b0100, 4'b0010, 8'h18, 0);
    add(0, 4'b1010, 4'b0000, mk(0, 11'h022, 11'h0A0, 11'h000), 4'b1000, 4'b0100, 8'hFC, 0);
    add(0, 4'b0010, 4'b0000, mk(0, 11'h022, 11'h0A0, 11'h000), 4'b0010, 4'b1000, 8'hFF, 0);
    add(0, 4'b0000, 4'b0000, mk(0, 11'h022, 11'h0A0, 11'h000), 4'b0000, 4'b0010, 8'h18, 0);
    add(0, 4'b0000, 4'b0000, mk(0, 11'h022, 11'h0A0, 11'h000), 4'b0000, 4'b0000, 8'h00, 0);
    run_table();

    // Reset asserted between edges in the middle of a burst by requester 0.
    @(negedge clk);
    bus.req = 4'b0001; bus.lock = 4'b0001; bus.addr_in = mk(11'h030, 11'h020, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("midburst busy before reset", 32'(bus.busy), 32'h1);
    chk("midburst gnt before reset", 32'(bus.gnt), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("async reset gnt", 32'(bus.gnt), 32'h0);
    chk("async reset rd_valid", 32'(bus.rd_valid), 32'h0);
    chk("async reset busy", 32'(bus.busy), 32'h0);
    chk("async reset rom_addr", 32'(bus.rom_addr), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    bus.req = 4'b0011; bus.lock = 4'b0000;
    @(posedge clk);
    #1;
    chk("post reset ptr0 gnt", 32'(bus.gnt), 32'h1);
    chk("post reset rd_valid", 32'(bus.rd_valid), 32'h0);
    @(negedge clk);
    bus.req = 4'b0010;
    @(posedge clk);
    #1;
    chk("post reset next gnt", 32'(bus.gnt), 32'h2);
    chk("post reset rd_valid0", 32'(bus.rd_valid), 32'h1);
    @(negedge clk);
    bus.req = 4'b0000;
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/font_rom_arbiter.md
Name: font_rom_arbiter

Overview:
- Shares the single-port registered font ROM between N text-rendering requesters: score text, ball-count text, "PONG" logo and game-over banner.
- Uses round-robin arbitration, issues one ROM read per cycle and returns each read with a requester tag.
- Supports locked bursts, so one requester can fetch a whole 16-row glyph back-to-back.
- Sits between the text generators and the font ROM, inside the graphics pixel pipeline.

Parameters:
- N, 4, number of requesters (2..8).
- AW, 11, ROM address width.
- DW, 8, ROM data width.
- MAX_BURST, 16, maximum consecutive grants to one locked requester before forced rotation.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  N  per-requester read request; level, held until the matching gnt bit is seen.
- lock  in  N  per-requester burst hint; sampled with req.
- addr_in  in  N*AW  packed request addresses; requester i occupies bits [i*AW +: AW]; held stable while req[i] is high.
- gnt  out  N  one-hot grant, registered; at most one bit high.
- rom_addr  out  AW  address to font ROM, registered.
- rom_data  in  DW  font ROM registered output (data_reg); one-cycle latency after rom_addr.
- rd_valid  out  N  one-hot read-return strobe.
- rd_data  out  DW  returned glyph row, equal to rom_data.
- busy  out  1  high while state is BURST.

Behaviour:
- Reset (async, active-high):
  - gnt=0, rd_valid=0, rom_addr=0, busy=0.
  - Round-robin pointer ptr=0, burst counter bcnt=0, state=IDLE.
  - rd_data follows rom_data.
- Timing, with edge E0 sampling req:
  - gnt[w] and rom_addr=addr_in[w] are valid in the cycle after E0.
  - The ROM captures at E1.
  - rd_valid[w] is high for exactly one cycle after E1, with rd_data = ROM word. Latency is req-to-rd_valid = 2 edges.
  - Throughput is one read per cycle, fully pipelined. rd_valid is gnt delayed one cycle.
- Requester rule: after seeing gnt[i], the requester either deasserts req[i] or presents the next address. The arbiter treats a still-high req[i] as a new request.
- IDLE state:
  - If req==0: gnt=0 and rom_addr holds its last value.
  - Otherwise grant the first set req bit searching from ptr upward with wrap (ptr, ptr+1, ..., N-1, 0, ...).
  - On a grant to w: ptr <= (w+1) mod N.
  - If lock[w] is also high: go to BURST with bcnt=1.
- BURST state (owner w):
  - While req[w]&&lock[w] and bcnt<MAX_BURST: grant w every cycle, bcnt++, ptr not updated.
  - Exit to IDLE arbitration in the same cycle when req[w] drops, lock[w] drops, or bcnt reaches MAX_BURST. The next grant then goes to the round-robin winner from ptr=(w+1) mod N, with no idle bubble.
  - If another requester is waiting at exit, that requester wins before w is re-granted (w is last in rotation order).
  - Worst-case wait for any requester = (N-1)*MAX_BURST cycles.
- Simultaneous events:
  - req rising on a lower-index requester during a burst does not preempt.
  - req[w] and lock[w] dropping on the same edge: a single exit.
- Reset mid-burst:
  - Everything clears immediately.
  - Any in-flight rd_valid is lost; requesters must re-request.
- ROM address is passed through unmodified. Only the low AW bits of each slice are used.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined:
  - Fixed priority, lowest index wins. ptr is unused and tied to 0.
  - Bursts are still limited by MAX_BURST. At burst exit, the same requester may be re-granted if it has the lowest index.
- Undefined: round-robin as above.

Test Plan:
- Reset then single req[0] with addr 0x022, lock=0 → gnt=4'b0001 one cycle later; next cycle rd_valid=4'b0001, rd_data=0x18; gnt returns to 0 when req drops.
- req=4'b1111 held, addresses 0x000/0x020/0x100/0x0A0, lock=0 → grants rotate 0,1,2,3,0; rd_data sequence 0xFF, 0x00, 0xF0, 0xFC aligned with rd_valid tags.
- req[2] lock[2] presenting 0x100..0x10F, req[0] also high from the first cycle → 16 consecutive gnt[2] (busy=1), then gnt[0]. With MAX_BURST=16, a 17th lock cycle is not granted to 2.
- Burst owner 1, lock drops after 3 rows → exactly 3 grants to 1, then next waiting requester (index 2 if requesting, else 3, 0) with no bubble cycle.
- Reset asserted asynchronously mid-burst between edges → gnt, rd_valid, busy go to 0 immediately. After release, arbitration restarts from ptr=0.
- With ARB_FIXED_PRIO_EN: req=4'b1010 held → gnt[1] every cycle, requester 3 starved; rd_valid=4'b0010 continuously.
